// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and event payload for the PS/2 scan-code decoder.
package ps2_pkg;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_FC = 8'hFC;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_EE = 8'hEE;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_00 = 8'h00;
    localparam logic [7:0] BYTE_FF = 8'hFF;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam int unsigned SKIP_W     = 3;
    localparam int unsigned PAUSE_SKIP = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_REL,
        ST_EXT_REL,
        ST_PAUSE
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } evt_t;

    // One-hot {up, down, left, right} bit for an arrow code, zero otherwise.
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] m;
        m = 4'b0000;
        case (code)
            KEY_UP:    m = 4'b1000;
            KEY_DOWN:  m = 4'b0100;
            KEY_LEFT:  m = 4'b0010;
            KEY_RIGHT: m = 4'b0001;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Byte-stream input, event stream output and status bundle of the scan decoder.
interface ps2_scan_decoder_if;
    import ps2_pkg::*;

    logic       BYTE_VALID;
    logic       BYTE_ERR;
    logic [7:0] BYTE_DATA;
    logic       EVT_VALID;
    logic       EVT_READY;
    logic [7:0] EVT_CODE;
    logic       EVT_EXT;
    logic       EVT_REL;
    logic [3:0] ARROW_HELD;
    logic       BAT_OK;
    logic       BAT_FAIL;
    logic       OVERFLOW;
    logic [7:0] ERR_CNT;

    // Receiver/consumer side.
    modport master (
        output BYTE_VALID, BYTE_ERR, BYTE_DATA, EVT_READY,
        input  EVT_VALID, EVT_CODE, EVT_EXT, EVT_REL,
        input  ARROW_HELD, BAT_OK, BAT_FAIL, OVERFLOW, ERR_CNT
    );

    // Decoder side.
    modport slave (
        input  BYTE_VALID, BYTE_ERR, BYTE_DATA, EVT_READY,
        output EVT_VALID, EVT_CODE, EVT_EXT, EVT_REL,
        output ARROW_HELD, BAT_OK, BAT_FAIL, OVERFLOW, ERR_CNT
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word fall-through event FIFO with a registered head entry.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic push,
    input  evt_t din,
    input  logic pop,
    output logic push_accept_c,
    output logic full_c,
    output logic empty_c,
    output evt_t head,
    output logic head_valid
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    evt_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   rd_nxt;
    logic [AW:0]   count;
    evt_t          head_d;
    logic          head_valid_d;

    assign count         = wr_ptr - rd_ptr;
    assign rd_nxt        = rd_ptr + (AW+1)'(1);
    assign empty_c       = (wr_ptr == rd_ptr);
    assign full_c        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_accept_c = push && (!full_c || pop);

    // Next head entry: refilled on a pop, or loaded by a push into an empty FIFO.
    always_comb begin
        head_d       = head;
        head_valid_d = head_valid;
        if (pop) begin
            if (count == (AW+1)'(1)) begin
                if (push_accept_c) begin
                    head_d       = din;
                    head_valid_d = 1'b1;
                end else begin
                    head_d       = '0;
                    head_valid_d = 1'b0;
                end
            end else begin
                head_d = mem[rd_nxt[AW-1:0]];
            end
        end else if (empty_c && push_accept_c) begin
            head_d       = din;
            head_valid_d = 1'b1;
        end
    end

    // Pointer and head registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push_accept_c) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)           rd_ptr <= rd_nxt;
            head       <= head_d;
            head_valid <= head_valid_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge CLK) begin
        if (push_accept_c) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: prefix FSM, pause skipper, arrow tracking, status and event FIFO.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    ps2_scan_decoder_if.slave   bus
);

    state_t              state_q, state_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [3:0]          arrow_q, arrow_d;
    logic                bat_ok_q, bat_ok_d;
    logic                bat_fail_q, bat_fail_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                emit;
    evt_t                evt;
    logic                fifo_push_accept_c;
    logic                fifo_full_c;
    logic                fifo_empty_c;
    logic                fifo_pop_c;
    evt_t                fifo_head;
    logic                fifo_head_valid;

    assign fifo_pop_c = bus.EVT_READY && !fifo_empty_c;

    ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK           (CLK),
        .RST           (RST),
        .push          (emit),
        .din           (evt),
        .pop           (fifo_pop_c),
        .push_accept_c (fifo_push_accept_c),
        .full_c        (fifo_full_c),
        .empty_c       (fifo_empty_c),
        .head          (fifo_head),
        .head_valid    (fifo_head_valid)
    );

    // State and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            arrow_q    <= '0;
            bat_ok_q   <= 1'b0;
            bat_fail_q <= 1'b0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            arrow_q    <= arrow_d;
            bat_ok_q   <= bat_ok_d;
            bat_fail_q <= bat_fail_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Byte decode: prefix tracking, event emission and status updates.
    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        arrow_d    = arrow_q;
        bat_ok_d   = bat_ok_q;
        bat_fail_d = bat_fail_q;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;
        emit       = 1'b0;
        evt        = '0;

        if (bus.BYTE_VALID) begin
            if (bus.BYTE_ERR) begin
                state_d = ST_IDLE;
                skip_d  = '0;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        case (bus.BYTE_DATA)
                            BYTE_E0: state_d = ST_EXT;
                            BYTE_F0: state_d = ST_REL;
                            BYTE_E1: begin
                                emit     = 1'b1;
                                evt.code = BYTE_E1;
                                skip_d   = SKIP_W'(PAUSE_SKIP);
                                state_d  = ST_PAUSE;
                            end
                            BYTE_AA: bat_ok_d   = 1'b1;
                            BYTE_FC: bat_fail_d = 1'b1;
                            BYTE_FA, BYTE_EE, BYTE_FE, BYTE_00, BYTE_FF: ;
                            default: begin
                                emit     = 1'b1;
                                evt.code = bus.BYTE_DATA;
                            end
                        endcase
                    end
                    ST_EXT: begin
                        if (bus.BYTE_DATA == BYTE_F0) begin
                            state_d = ST_EXT_REL;
                        end else if (bus.BYTE_DATA != BYTE_E0) begin
                            emit     = 1'b1;
                            evt.ext  = 1'b1;
                            evt.code = bus.BYTE_DATA;
                            state_d  = ST_IDLE;
                        end
                    end
                    ST_REL: begin
                        if (bus.BYTE_DATA == BYTE_E0) begin
                            state_d = ST_EXT;
                        end else if (bus.BYTE_DATA != BYTE_F0) begin
                            emit     = 1'b1;
                            evt.rel  = 1'b1;
                            evt.code = bus.BYTE_DATA;
                            state_d  = ST_IDLE;
                        end
                    end
                    ST_EXT_REL: begin
                        if (bus.BYTE_DATA != BYTE_E0 && bus.BYTE_DATA != BYTE_F0) begin
                            emit     = 1'b1;
                            evt.ext  = 1'b1;
                            evt.rel  = 1'b1;
                            evt.code = bus.BYTE_DATA;
                            state_d  = ST_IDLE;
                        end
                    end
                    ST_PAUSE: begin
                        skip_d = skip_q - SKIP_W'(1);
                        if (skip_q <= SKIP_W'(1)) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        // Arrow state follows extended makes/breaks even when the FIFO drops the event.
        if (emit && evt.ext) begin
            if (evt.rel) arrow_d = arrow_q & ~arrow_mask(evt.code);
            else         arrow_d = arrow_q |  arrow_mask(evt.code);
        end

        if (emit && fifo_full_c && !fifo_push_accept_c) overflow_d = 1'b1;
    end

    assign bus.EVT_VALID  = fifo_head_valid;
    assign bus.EVT_CODE   = fifo_head.code;
    assign bus.EVT_EXT    = fifo_head.ext;
    assign bus.EVT_REL    = fifo_head.rel;
    assign bus.ARROW_HELD = arrow_q;
    assign bus.BAT_OK     = bat_ok_q;
    assign bus.BAT_FAIL   = bat_fail_q;
    assign bus.OVERFLOW   = overflow_q;
    assign bus.ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder with an event scoreboard and decoupled monitor.
module tb_ps2_scan_decoder;
    import ps2_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    evt_t exp_q[$];

    ps2_scan_decoder_if bus();

    ps2_scan_decoder #(.FIFO_DEPTH(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic expect_evt(input logic ext, input logic rel, input logic [7:0] code);
        evt_t e;
        e.ext  = ext;
        e.rel  = rel;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input logic err);
        bus.BYTE_VALID = 1'b1;
        bus.BYTE_DATA  = b;
        bus.BYTE_ERR   = err;
        @(posedge clk); #1;
        bus.BYTE_VALID = 1'b0;
        bus.BYTE_ERR   = 1'b0;
        bus.BYTE_DATA  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head entry must match the oldest expected event.
    initial begin
        evt_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.EVT_VALID && bus.EVT_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event got=%0h_%0b%0b exp=none",
                             bus.EVT_CODE, bus.EVT_EXT, bus.EVT_REL);
                end else begin
                    e = exp_q.pop_front();
                    check("event", {22'd0, bus.EVT_EXT, bus.EVT_REL, bus.EVT_CODE}, {22'd0, e});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.BYTE_VALID = 1'b0;
        bus.BYTE_ERR   = 1'b0;
        bus.BYTE_DATA  = 8'h00;
        bus.EVT_READY  = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);

        check("rst_evt_valid", 32'(bus.EVT_VALID), 32'd0);
        check("rst_evt_head",  32'({bus.EVT_CODE, bus.EVT_EXT, bus.EVT_REL}), 32'd0);
        check("rst_arrow",     32'(bus.ARROW_HELD), 32'd0);
        check("rst_flags",     32'({bus.BAT_OK, bus.BAT_FAIL, bus.OVERFLOW}), 32'd0);
        check("rst_err_cnt",   32'(bus.ERR_CNT), 32'd0);

        // Plain make, then release.
        expect_evt(1'b0, 1'b0, 8'h1C);
        send(8'h1C, 1'b0);
        check("make_latency", 32'(bus.EVT_VALID), 32'd1);
        idle(3);
        send(8'hF0, 1'b0);
        check("prefix_no_evt", 32'(bus.EVT_VALID), 32'd0);
        expect_evt(1'b0, 1'b1, 8'h1C);
        send(8'h1C, 1'b0);
        check("break_latency", 32'(bus.EVT_VALID), 32'd1);
        idle(3);

        // Extended arrow make, typematic repeats, then break.
        for (int i = 0; i < 3; i++) begin
            send(8'hE0, 1'b0);
            expect_evt(1'b1, 1'b0, 8'h75);
            send(8'h75, 1'b0);
            check("arrow_make", 32'(bus.ARROW_HELD), 32'h8);
        end
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        expect_evt(1'b1, 1'b1, 8'h75);
        send(8'h75, 1'b0);
        check("arrow_break", 32'(bus.ARROW_HELD), 32'h0);
        idle(3);

        // Error byte discards a pending release prefix.
        send(8'hF0, 1'b0);
        send(8'h55, 1'b1);
        expect_evt(1'b0, 1'b0, 8'h1C);
        send(8'h1C, 1'b0);
        check("err_cnt_one", 32'(bus.ERR_CNT), 32'd1);
        idle(3);

        // Pause sequence: only E1 is reported, the 7 trailing bytes are skipped.
        expect_evt(1'b0, 1'b0, 8'hE1);
        send(8'hE1, 1'b0);
        send(8'h14, 1'b0);
        send(8'h77, 1'b0);
        send(8'hE1, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h14, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h77, 1'b0);
        expect_evt(1'b0, 1'b0, 8'h29);
        send(8'h29, 1'b0);
        check("pause_arrow", 32'(bus.ARROW_HELD), 32'h0);
        idle(3);

        // Overflow with a stalled consumer, then push+pop while full.
        bus.EVT_READY = 1'b0;
        expect_evt(1'b0, 1'b0, 8'h15); send(8'h15, 1'b0);
        expect_evt(1'b0, 1'b0, 8'h16); send(8'h16, 1'b0);
        expect_evt(1'b0, 1'b0, 8'h1E); send(8'h1E, 1'b0);
        expect_evt(1'b0, 1'b0, 8'h26); send(8'h26, 1'b0);
        check("no_overflow_yet", 32'(bus.OVERFLOW), 32'd0);
        send(8'h25, 1'b0);
        check("overflow_set", 32'(bus.OVERFLOW), 32'd1);
        check("full_head", 32'(bus.EVT_CODE), 32'h15);
        bus.EVT_READY = 1'b1;
        expect_evt(1'b0, 1'b0, 8'h2E);
        send(8'h2E, 1'b0);
        bus.EVT_READY = 1'b0;
        check("full_pushpop_head", 32'(bus.EVT_CODE), 32'h16);
        idle(3);
        bus.EVT_READY = 1'b1;
        idle(8);
        check("drained_valid", 32'(bus.EVT_VALID), 32'd0);
        check("drained_queue", 32'(exp_q.size()), 32'd0);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) send(8'h00, 1'b1);
        check("err_cnt_sat", 32'(bus.ERR_CNT), 32'd255);

        // Reset mid-sequence discards the E0 prefix and clears sticky state.
        send(8'hE0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst2_evt_valid", 32'(bus.EVT_VALID), 32'd0);
        check("rst2_arrow",     32'(bus.ARROW_HELD), 32'd0);
        check("rst2_flags",     32'({bus.BAT_OK, bus.BAT_FAIL, bus.OVERFLOW}), 32'd0);
        check("rst2_err_cnt",   32'(bus.ERR_CNT), 32'd0);
        expect_evt(1'b0, 1'b0, 8'h75);
        send(8'h75, 1'b0);
        check("post_rst_arrow", 32'(bus.ARROW_HELD), 32'd0);
        idle(3);

        // Self-test result bytes set sticky flags without events.
        send(8'hAA, 1'b0);
        check("bat_ok", 32'({bus.BAT_OK, bus.BAT_FAIL}), 32'b10);
        check("bat_no_evt", 32'(bus.EVT_VALID), 32'd0);
        send(8'hFC, 1'b0);
        check("bat_fail", 32'({bus.BAT_OK, bus.BAT_FAIL}), 32'b11);
        send(8'hFA, 1'b0);
        send(8'hFF, 1'b0);
        check("ignored_no_evt", 32'(bus.EVT_VALID), 32'd0);
        idle(5);

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
